gray_seq_gen: RTL and testbench
===============================

Name: gray_seq_gen

Overview:
- Upstream source stage for the greytobinary converter.
- Generates a complete Gray-code sequence of 2^WIDTH words, up or down, from a loadable start value.
- Presents each word on a valid/ready handshake.
- g_out connects directly to the converter's G input; the handshake lets the consumer apply backpressure.

Parameters:
- WIDTH, 4, code word width in bits (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sequence; honoured only in IDLE.
- dir  input  1  0 = count up, 1 = count down; sampled with start.
- load  input  1  load start value; honoured only in IDLE.
- load_bin  input  WIDTH  binary start value for load.
- g_ready  input  1  consumer accepts g_out this cycle.
- g_out  output  WIDTH  registered Gray word, equal to bin ^ (bin >> 1).
- g_valid  output  1  g_out holds a word to transfer.
- busy  output  1  high in RUN and DONE.
- wrap  output  1  one-cycle pulse when the internal binary count crosses its wrap boundary.
- done  output  1  one-cycle pulse at sequence end.
- err  output  1  sticky single-bit-step violation flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, bin = 0, step count = 0, dir_q = 0.
  - g_out = 0; g_valid, busy, wrap, done, err = 0.
  - Released synchronously on the next clk edge after rst_n rises.
- Internal registers:
  - bin: WIDTH-bit binary count.
  - step: WIDTH+1-bit transfer counter.
  - dir_q: latched direction.
  - g_out is always registered as gray(bin next).
- Arithmetic: bin ± 1 modulo 2^WIDTH; no saturation.
- State machine:
  - IDLE:
    - g_valid = 0.
    - load = 1: bin <= load_bin and g_out <= gray(load_bin) next cycle.
    - start = 1: dir_q <= dir, step <= 0, go to RUN; g_valid = 1 the next cycle.
    - load and start in the same cycle: the load is applied and the sequence begins from load_bin.
  - RUN:
    - g_valid = 1.
    - Transfer = g_valid & g_ready at a clk edge.
    - On transfer: bin <= bin + 1 (dir_q = 0) or bin - 1 (dir_q = 1); g_out updates the next cycle; step increments.
    - Without transfer, g_out and g_valid hold stable (no change while stalled).
    - The transfer that makes step = 2^WIDTH moves to DONE. bin has then returned to its start value.
    - start, load and dir are ignored in RUN.
  - DONE:
    - Lasts exactly one cycle; g_valid = 0, done = 1, then IDLE.
- Latency: start to first valid word = 1 cycle; transfer to next word = 1 cycle. With g_ready held high, one word per cycle.
- wrap:
  - Pulses high the cycle after a transfer where bin went all-ones -> 0 (up) or 0 -> all-ones (down).
  - May coincide with done.
- Reset asserted mid-RUN: immediate return to the reset state. Any word in flight is dropped, with no done pulse.

Optional Feature:
- Macro: GRAY_SEQ_CHECK_EN.
- Defined:
  - On every transfer, the logic compares the previous and new g_out.
  - If they differ in a number of bits other than exactly one, err sets high and stays high until reset.
  - The comparison includes the wrap step.
- Undefined: err is tied to 0 and no check logic is synthesised.

Test Plan:
- Reset: rst_n = 0 mid-cycle -> all outputs 0 asynchronously. After release, g_out = 4'h0, g_valid = 0.
- Full up sequence, WIDTH = 4, start value 0, g_ready = 1, dir = 0:
  - g_out = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 on consecutive cycles.
  - Then wrap = 1 and done = 1 in the same cycle, then IDLE.
  - Converter output B = 0..15.
- Load and down count: load_bin = 5, then start with dir = 1:
  - First word 7 (gray 5), then 6, 2, 3, 1, 0, 8, ...
  - wrap pulses after the 0 -> F step (gray 0 -> 8).
  - 16 words in total, then done.
- Backpressure: toggle g_ready 1, 0, 0, 1 during RUN -> g_out holds its value for the stalled cycles, with no skipped or duplicated word. done arrives after exactly 16 transfers.
- Ignored controls: assert load = 1 with load_bin = A, and start = 1, mid-RUN -> sequence unaffected and bin not reloaded.
- Mid-run reset and check feature:
  - Reset after 3 transfers -> done never pulses; a new start yields gray(0) first.
  - With GRAY_SEQ_CHECK_EN defined, err stays 0 across all the above.

Source files
------------

// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: walks all 2^WIDTH codes up or down from a loadable
// binary start value over a valid/ready handshake. Optional step checker: GRAY_SEQ_CHECK_EN.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             g_ready,
  output logic [WIDTH-1:0] g_out,
  output logic             g_valid,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   STEP_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   STEP_LAST = {1'b0, {WIDTH{1'b1}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH:0]   step_q, step_d;
  logic             dir_q, dir_d;
  logic             wrap_d;
  logic             xfer;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Handshake: a word moves when g_valid and g_ready are both high at a rising
  // edge; while g_valid is high and g_ready low, g_out and g_valid hold stable.
  assign xfer = (state_q == RUN) && g_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    step_d  = step_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) bin_d = load_bin;
        if (start) begin
          dir_d   = dir;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          bin_d  = dir_q ? (bin_q - ONE) : (bin_q + ONE);
          step_d = step_q + STEP_ONE;
          wrap_d = dir_q ? (bin_q == '0) : (bin_q == ALL_ONES);
          // Final transfer: bin is back at its start value.
          if (step_q == STEP_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      g_out   <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      g_out   <= to_gray(bin_d);
      wrap    <= wrap_d;
    end
  end

  assign g_valid = (state_q == RUN);
  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);

`ifdef GRAY_SEQ_CHECK_EN
  logic [WIDTH-1:0] diff;
  logic             one_hot;

  // Exactly one differing bit: non-zero and a power of two.
  assign diff    = g_out ^ to_gray(bin_d);
  assign one_hot = (diff != '0) && ((diff & (diff - ONE)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (xfer && !one_hot) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: table-driven sequences, hand-written corner cases and
// randomized runs against a queue-based reference of the expected word stream.
module tb_gray_seq_gen;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic         g_ready = 1'b0;
  logic [W-1:0] g_out;
  logic         g_valid, busy, wrap, done, err;

  gray_seq_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .load(load),
    .load_bin(load_bin), .g_ready(g_ready), .g_out(g_out), .g_valid(g_valid),
    .busy(busy), .wrap(wrap), .done(done), .err(err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int n_xfer, wrap_at, done_cnt;
  logic wrap_at_done, busy_at_done, vld_at_done;

  typedef struct {
    int s;
    int d;
    int ld;
    int first;
    int second;
    int last;
    int wrap_done;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input int b);
    int m;
    m = ((b % N) + N) % N;
    return W'(m ^ (m >> 1));
  endfunction

  // Reference: the expected word list is start +/- i (mod N), and the wrap
  // point is the transfer whose new count crosses the N-1 / 0 boundary.
  task automatic build_model(input int s, input int d, output int exp_wrap);
    int nb;
    exp_q.delete();
    exp_wrap = -1;
    for (int i = 0; i < N; i++) exp_q.push_back(to_gray(d ? s - i : s + i));
    for (int i = 1; i <= N; i++) begin
      nb = (((d ? s - i : s + i) % N) + N) % N;
      if ((d == 0 && nb == 0) || (d == 1 && nb == N - 1)) exp_wrap = i;
    end
  endtask

  // ld: 0 = no load, 1 = load with start, 2 = load one cycle before start
  task automatic begin_seq(input int s, input int d, input int ld);
    @(negedge clk);
    if (ld == 2) begin
      load = 1'b1;
      load_bin = W'(s);
      @(negedge clk);
      load = 1'b0;
    end
    load = (ld == 1);
    load_bin = W'(s);
    start = 1'b1;
    dir = d[0];
    @(negedge clk);
    start = 1'b0;
    load = 1'b0;
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
  task automatic run_seq(input int ready_mode, input bit noise);
    logic [3:0] pat;
    logic rdy, prev_stall;
    logic [W-1:0] prev_g;
    pat = 4'b1001;
    got_q.delete();
    n_xfer = 0; wrap_at = -1; done_cnt = 0;
    wrap_at_done = 0; busy_at_done = 0; vld_at_done = 1;
    prev_stall = 0; prev_g = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (wrap) wrap_at = n_xfer;
      if (done) begin
        done_cnt++;
        wrap_at_done = wrap;
        busy_at_done = busy;
        vld_at_done = g_valid;
        break;
      end
      if (prev_stall) begin
        check("stall_valid_hold", int'(g_valid), 1);
        check("stall_word_hold", int'(g_out), int'(prev_g));
      end
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = pat[cyc % 4];
      endcase
      g_ready = rdy;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        load = 1'($urandom_range(0, 1));
        load_bin = 4'hA;
        dir = 1'($urandom_range(0, 1));
      end
      if (g_valid && rdy) begin
        got_q.push_back(g_out);
        n_xfer++;
      end
      prev_stall = g_valid && !rdy;
      prev_g = g_out;
      @(negedge clk);
    end
    g_ready = 1'b0;
    start = 1'b0;
    load = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int exp_wrap);
    int n;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_xfer_count"}, got_q.size(), N);
    n = (got_q.size() < N) ? got_q.size() : N;
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    check({tag, "_wrap_pos"}, wrap_at, exp_wrap);
    check({tag, "_busy_at_done"}, int'(busy_at_done), 1);
    check({tag, "_valid_at_done"}, int'(vld_at_done), 0);
    check({tag, "_err"}, int'(err), 0);
    @(negedge clk);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_idle_done"}, int'(done), 0);
  endtask

  int exp_wrap, cur_bin, s, d, ld;
  int done_seen;

  initial begin
    vecs[0] = '{s: 0,  d: 0, ld: 1, first: 0,  second: 1,  last: 8,  wrap_done: 1};
    vecs[1] = '{s: 5,  d: 1, ld: 2, first: 7,  second: 6,  last: 5,  wrap_done: 0};
    vecs[2] = '{s: 10, d: 0, ld: 1, first: 15, second: 14, last: 13, wrap_done: 0};
    vecs[3] = '{s: 15, d: 1, ld: 1, first: 8,  second: 9,  last: 0,  wrap_done: 1};

    // reset state
    #3;
    check("reset_g_out", int'(g_out), 0);
    check("reset_g_valid", int'(g_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_wrap_done", int'({wrap, done}), 0);
    check("reset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_g_out", int'(g_out), 0);
    check("post_reset_g_valid", int'(g_valid), 0);

    // table-driven full sequences with g_ready held high
    foreach (vecs[i]) begin
      build_model(vecs[i].s, vecs[i].d, exp_wrap);
      begin_seq(vecs[i].s, vecs[i].d, vecs[i].ld);
      run_seq(0, 1'b0);
      if (got_q.size() == N) begin
        check($sformatf("vec%0d_first", i), int'(got_q[0]), vecs[i].first);
        check($sformatf("vec%0d_second", i), int'(got_q[1]), vecs[i].second);
        check($sformatf("vec%0d_last", i), int'(got_q[N-1]), vecs[i].last);
      end
      check($sformatf("vec%0d_wrap_with_done", i), int'(wrap_at_done), vecs[i].wrap_done);
      check_seq($sformatf("vec%0d", i), exp_wrap);
    end

    // backpressure with the 1,0,0,1 ready pattern
    build_model(3, 0, exp_wrap);
    begin_seq(3, 0, 1);
    run_seq(2, 1'b0);
    check_seq("backpressure", exp_wrap);

    // start/load/dir noise during RUN must be ignored
    build_model(6, 1, exp_wrap);
    begin_seq(6, 1, 1);
    run_seq(1, 1'b1);
    check_seq("ignored_ctrl", exp_wrap);
    // count was not reloaded with 0xA: a start without load begins at 6
    build_model(6, 0, exp_wrap);
    begin_seq(0, 0, 0);
    run_seq(0, 1'b0);
    check_seq("no_reload", exp_wrap);
    cur_bin = 6;

    // randomized sequences
    for (int r = 0; r < 8; r++) begin
      ld = $urandom_range(0, 2);
      s = (ld == 0) ? cur_bin : int'($urandom_range(0, N - 1));
      d = $urandom_range(0, 1);
      build_model(s, d, exp_wrap);
      begin_seq(s, d, ld);
      run_seq(1, 1'($urandom_range(0, 1)));
      check_seq($sformatf("rand%0d", r), exp_wrap);
      cur_bin = s;
    end

    // mid-run reset after 3 transfers
    begin_seq(9, 0, 1);
    g_ready = 1'b1;
    repeat (3) @(negedge clk);
    g_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_g_out", int'(g_out), 0);
    check("midreset_g_valid", int'(g_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midreset_no_done", done_seen, 0);
    build_model(0, 0, exp_wrap);
    begin_seq(0, 0, 0);
    run_seq(0, 1'b0);
    check_seq("after_reset", exp_wrap);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
